// File: rtl/io_switch_led_ctrl.sv
// Memory-mapped LED/switch peripheral: write-only LED registers, synchronized and
// debounced switch inputs, combinational read-back with a sticky change flag.
module io_switch_led_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned CNT_W           = 32'd20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic [7:0]  io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic        sw_event
);

  localparam logic [7:0] ADDR_LED_LO = 8'h60;
  localparam logic [7:0] ADDR_LED_HI = 8'h62;
  localparam logic [7:0] ADDR_SW_LO  = 8'h70;
  localparam logic [7:0] ADDR_SW_HI  = 8'h72;
  localparam logic [7:0] ADDR_STATUS = 8'h74;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [23:0]      led_q, led_d;
  logic [23:0]      sync1_q, sync2_q;
  logic [23:0]      cand_q, cand_d;
  logic [23:0]      stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_event_q, sw_event_d;
  logic             upd_s;
  logic             clr_s;

  always_comb begin
    led_d = led_q;
    if (LEDCtrl) begin
      case (io_addr)
        ADDR_LED_LO: led_d[15:0]  = io_wdata;
        ADDR_LED_HI: led_d[23:16] = io_wdata[7:0];
        default:     led_d        = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
  end

  // The whole vector shares one counter: any bit moving restarts the qualification.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd_s    = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      if (cand_q != stable_q) begin
        stable_d = cand_q;
        upd_s    = 1'b1;
      end else begin
        stable_d = stable_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // A fresh update outranks a clearing status read in the same cycle.
  always_comb begin
    sw_event_d = sw_event_q;
    clr_s      = SwitchCtrl && (io_addr == ADDR_STATUS);
    if (upd_s) begin
      sw_event_d = 1'b1;
    end else if (clr_s) begin
      sw_event_d = 1'b0;
    end else begin
      sw_event_d = sw_event_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q      <= 24'h000000;
      sync1_q    <= 24'h000000;
      sync2_q    <= 24'h000000;
      cand_q     <= 24'h000000;
      stable_q   <= 24'h000000;
      cnt_q      <= CNT_ZERO;
      sw_event_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      sync1_q    <= switch_in;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      sw_event_q <= sw_event_d;
    end
  end

  // Combinational so a single-cycle load sees the data in the same cycle.
  always_comb begin
    io_rdata = 16'h0000;
    if (SwitchCtrl) begin
      case (io_addr)
        ADDR_SW_LO:  io_rdata = stable_q[15:0];
        ADDR_SW_HI:  io_rdata = {8'h00, stable_q[23:16]};
        ADDR_STATUS: io_rdata = {15'h0000, sw_event_q};
        default:     io_rdata = 16'h0000;
      endcase
    end else begin
      io_rdata = 16'h0000;
    end
  end

  assign led_out  = led_q;
  assign sw_event = sw_event_q;

endmodule

// File: tb/tb_io_switch_led_ctrl.sv
// Bench for io_switch_led_ctrl: directed scenarios followed by random traffic, all
// checked against a window-based reference model of the debounce behaviour.
module tb_io_switch_led_ctrl;

  localparam int D = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic [23:0] switch_in;
  logic [23:0] led_out;
  logic        sw_event;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  logic [23:0] m_led;
  logic [23:0] m_stable;
  logic        m_event;
  logic [23:0] hist[$];

  io_switch_led_ctrl #(.DEBOUNCE_CYCLES(32'd8), .CNT_W(32'd4)) dut (
    .clock(clock), .reset(reset), .LEDCtrl(LEDCtrl), .SwitchCtrl(SwitchCtrl),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .switch_in(switch_in), .led_out(led_out), .sw_event(sw_event)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_led    = 24'h000000;
    m_stable = 24'h000000;
    m_event  = 1'b0;
    hist     = {};
    repeat (D + 2) hist.push_back(24'h000000);
  endtask

  // hist holds the inputs seen at the previous D+2 edges, oldest first; a value is
  // accepted once it was seen at D+1 consecutive edges, ending two edges ago.
  task automatic model_edge();
    logic [23:0] v;
    bit          same;
    bit          set;
    v    = hist[0];
    same = 1'b1;
    for (int i = 1; i <= D; i++) if (hist[i] != v) same = 1'b0;
    set = same && (v != m_stable);
    if (set) begin
      m_stable = v;
      m_event  = 1'b1;
    end else if (SwitchCtrl && io_addr == 8'h74) begin
      m_event = 1'b0;
    end
    if (LEDCtrl && io_addr == 8'h60) m_led[15:0]  = io_wdata;
    if (LEDCtrl && io_addr == 8'h62) m_led[23:16] = io_wdata[7:0];
    void'(hist.pop_front());
    hist.push_back(switch_in);
  endtask

  function automatic logic [15:0] exp_rdata();
    if (!SwitchCtrl)           return 16'h0000;
    if (io_addr == 8'h70)      return m_stable[15:0];
    if (io_addr == 8'h72)      return {8'h00, m_stable[23:16]};
    if (io_addr == 8'h74)      return {15'h0000, m_event};
    return 16'h0000;
  endfunction

  task automatic step();
    @(posedge clock);
    if (!reset) model_reset();
    else        model_edge();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    #1;
    chk({tag, "_rd"},  {8'h00, io_rdata}, {8'h00, exp_rdata()});
    chk({tag, "_led"}, led_out, m_led);
    chk({tag, "_evt"}, {23'h0, sw_event}, {23'h0, m_event});
  endtask

  task automatic bus(input logic lc, input logic sc, input logic [7:0] a, input logic [15:0] wd);
    LEDCtrl    = lc;
    SwitchCtrl = sc;
    io_addr    = a;
    io_wdata   = wd;
  endtask

  initial begin
    int hold;
    reset     = 1'b1;
    switch_in = 24'h000000;
    bus(1'b0, 1'b0, 8'h00, 16'h0000);
    #2;
    reset = 1'b0;
    model_reset();
    switch_in = 24'hFFFFFF;
    bus(1'b1, 1'b1, 8'h60, 16'hFFFF);
    @(negedge clock);

    // reset holds everything at zero despite active strobes
    for (int k = 0; k < 3; k++) begin
      if (k == 2) io_addr = 8'h70;
      #1;
      chk("rst_led", led_out, 24'h000000);
      chk("rst_evt", {23'h0, sw_event}, 24'h000000);
      chk("rst_rd",  {8'h00, io_rdata}, 24'h000000);
      step();
    end
    reset     = 1'b1;
    switch_in = 24'h000000;
    bus(1'b0, 1'b1, 8'h70, 16'h0000);
    for (int k = 0; k < 12; k++) begin chk_all("idle"); step(); end

    // glitch shorter than the debounce window
    switch_in = 24'h000001;
    for (int k = 0; k < 5; k++) begin chk_all("glitch_on"); step(); end
    switch_in = 24'h000000;
    for (int k = 0; k < 15; k++) begin chk_all("glitch_off"); step(); end
    #1;
    chk("glitch_evt", {23'h0, sw_event}, 24'h000000);
    chk("glitch_rd",  {8'h00, io_rdata}, 24'h000000);

    // LED writes
    bus(1'b1, 1'b0, 8'h60, 16'hA5C3); step();
    bus(1'b1, 1'b0, 8'h62, 16'h1234); step();
    bus(1'b0, 1'b0, 8'h00, 16'h0000); #1;
    chk("led_wr", led_out, 24'h34A5C3);
    bus(1'b1, 1'b0, 8'h64, 16'hFFFF); step();
    bus(1'b0, 1'b0, 8'h00, 16'h0000); #1;
    chk("led_unmapped", led_out, 24'h34A5C3);

    // clean change accepted exactly D+3 edges later
    bus(1'b0, 1'b1, 8'h70, 16'h0000);
    switch_in = 24'h00F00F;
    for (int k = 1; k <= 12; k++) begin
      step();
      #1;
      chk("acc_rd", {8'h00, io_rdata}, (k >= D + 3) ? 24'h00F00F : 24'h000000);
      chk_all("acc");
    end
    io_addr = 8'h72; #1;
    chk("acc_rd_hi", {8'h00, io_rdata}, 24'h000000);
    chk("acc_evt",   {23'h0, sw_event}, 24'h000001);

    // update lands on the same edge as a clearing status read: set wins
    io_addr   = 8'h70;
    switch_in = 24'h0A0000;
    for (int k = 1; k <= D + 2; k++) begin step(); chk_all("coin"); end
    io_addr = 8'h74; #1;
    chk("coin_rd", {8'h00, io_rdata}, 24'h000001);
    step(); #1;
    chk("coin_evt", {23'h0, sw_event}, 24'h000001);
    io_addr = 8'h72; #1;
    chk("coin_hi", {8'h00, io_rdata}, 24'h00000A);

    // clear-on-read
    io_addr = 8'h74; #1;
    chk("clr_rd1", {8'h00, io_rdata}, 24'h000001);
    step(); #1;
    chk("clr_rd2", {8'h00, io_rdata}, 24'h000000);
    chk_all("clr");

    // reset in the middle of a debounce
    io_addr   = 8'h70;
    switch_in = 24'h123456;
    for (int k = 0; k < 4; k++) begin step(); chk_all("mid_pre"); end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("mid_rst_rd",  {8'h00, io_rdata}, 24'h000000);
      chk("mid_rst_led", led_out, 24'h000000);
      step();
    end
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      #1;
      chk("mid_rd", {8'h00, io_rdata}, (k >= D + 3) ? 24'h003456 : 24'h000000);
      chk_all("mid");
    end
    chk("mid_evt", {23'h0, sw_event}, 24'h000001);

    // random traffic
    hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        switch_in = $urandom() & 32'h00FFFFFF;
        hold = ($urandom_range(0, 9) < 7) ? $urandom_range(12, 20) : $urandom_range(1, 6);
      end
      hold--;
      LEDCtrl    = ($urandom_range(0, 3) == 0);
      SwitchCtrl = ($urandom_range(0, 1) == 1);
      io_wdata   = 16'($urandom());
      case ($urandom_range(0, 6))
        0:       io_addr = 8'h60;
        1:       io_addr = 8'h62;
        2:       io_addr = 8'h64;
        3:       io_addr = 8'h70;
        4:       io_addr = 8'h72;
        5:       io_addr = 8'h74;
        default: io_addr = 8'($urandom());
      endcase
      chk_all("rnd");
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
